// File: rtl/shift_reg_seq_ctrl.sv
// Sequencer that loads a word, serialises it MSB-first into an external SIPO
// shift register and returns the register's parallel output. Optional readback check: SHIFT_CHECK_EN.
module shift_reg_seq_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             Load_valid,
    output logic             Load_ready,
    input  logic [WIDTH-1:0] Load_data,
    input  logic             Flush,
    output logic             Shift_en,
    output logic             D,
    input  logic [WIDTH-1:0] Q,
    output logic             Out_valid,
    input  logic             Out_ready,
    output logic [WIDTH-1:0] Out_data,
    output logic             Busy,
    output logic             Mismatch
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, SETTLE, HOLD} state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
    logic [WIDTH-1:0] word, word_n;
    logic             shift_en_n, d_n, ov_n;
    logic [WIDTH-1:0] od_n;

    assign Load_ready = (state == IDLE);
    assign Busy       = (state != IDLE);

    // The word rotates once per SHIFT edge; after WIDTH rotations it is back
    // to its loaded value, so one register serves both serialiser and checker.
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        word_n     = word;
        shift_en_n = Shift_en;
        d_n        = D;
        ov_n       = Out_valid;
        od_n       = Out_data;
        cnt_inc    = cnt + 1'b1;
        if (Flush) begin
            state_n    = IDLE;
            cnt_n      = '0;
            shift_en_n = 1'b0;
            d_n        = 1'b0;
            ov_n       = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (Load_valid) begin
                        state_n    = SHIFT;
                        word_n     = Load_data;
                        d_n        = Load_data[WIDTH-1];
                        shift_en_n = 1'b1;
                        cnt_n      = '0;
                    end
                end
                SHIFT: begin
                    cnt_n  = cnt_inc;
                    word_n = {word[WIDTH-2:0], word[WIDTH-1]};
                    if (cnt_inc == CNT_W'(WIDTH)) begin
                        shift_en_n = 1'b0;
                        d_n        = 1'b0;
                        state_n    = SETTLE;
                    end else begin
                        d_n = word[WIDTH-2];
                    end
                end
                SETTLE: begin
                    od_n    = Q;
                    ov_n    = 1'b1;
                    state_n = HOLD;
                end
                HOLD: begin
                    if (Out_ready) begin
                        ov_n    = 1'b0;
                        state_n = IDLE;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            word      <= '0;
            Shift_en  <= 1'b0;
            D         <= 1'b0;
            Out_valid <= 1'b0;
            Out_data  <= '0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            word      <= word_n;
            Shift_en  <= shift_en_n;
            D         <= d_n;
            Out_valid <= ov_n;
            Out_data  <= od_n;
        end
    end

`ifdef SHIFT_CHECK_EN
    logic mism;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n)
            mism <= 1'b0;
        else if (Flush)
            mism <= 1'b0;
        else if (state == SETTLE)
            mism <= (Q != word);
        else if (state == HOLD && Out_ready)
            mism <= 1'b0;
    end

    assign Mismatch = mism;
`else
    assign Mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_shift_reg_seq_ctrl.sv
// Scoreboard bench for shift_reg_seq_ctrl with a behavioural 4-bit SIPO register on Q.
module tb_shift_reg_seq_ctrl;

    localparam int W = 4;

`ifdef SHIFT_CHECK_EN
    localparam logic STUCK_MISM = 1'b1;
`else
    localparam logic STUCK_MISM = 1'b0;
`endif

    logic         Clk = 1'b0;
    logic         Rst_n = 1'b0;
    logic         Load_valid = 1'b0;
    logic         Load_ready;
    logic [W-1:0] Load_data = '0;
    logic         Flush = 1'b0;
    logic         Shift_en;
    logic         D;
    logic [W-1:0] Q;
    logic         Out_valid;
    logic         Out_ready = 1'b0;
    logic [W-1:0] Out_data;
    logic         Busy;
    logic         Mismatch;

    always #5 Clk = ~Clk;

    shift_reg_seq_ctrl #(.WIDTH(W)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .Load_valid(Load_valid), .Load_ready(Load_ready),
        .Load_data(Load_data), .Flush(Flush), .Shift_en(Shift_en), .D(D), .Q(Q),
        .Out_valid(Out_valid), .Out_ready(Out_ready), .Out_data(Out_data),
        .Busy(Busy), .Mismatch(Mismatch)
    );

    // Register model; stuck forces Q[2] low at its output.
    logic [W-1:0] qreg = '0;
    logic         stuck = 1'b0;
    always @(posedge Clk) if (Shift_en) qreg <= {qreg[W-2:0], D};
    assign Q = stuck ? (qreg & 4'b1011) : qreg;

    typedef struct packed {
        logic [W-1:0] data;
        logic         mism;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(negedge Clk);
    endtask

    // Monitor: each rising Out_valid must match the oldest expected word.
    logic ov_prev = 1'b0;
    always @(negedge Clk) begin
        if (Out_valid && !ov_prev) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_out: got %0h, expected no output", Out_data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("out_data", {28'd0, Out_data}, {28'd0, e.data});
                check("out_mismatch", {31'd0, Mismatch}, {31'd0, e.mism});
            end
        end
        ov_prev <= Out_valid;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [W-1:0] w;

        // Reset state
        #3;
        check("rst_shift_en", {31'd0, Shift_en}, 0);
        check("rst_d", {31'd0, D}, 0);
        check("rst_out_valid", {31'd0, Out_valid}, 0);
        check("rst_out_data", {28'd0, Out_data}, 0);
        check("rst_busy", {31'd0, Busy}, 0);
        check("rst_load_ready", {31'd0, Load_ready}, 1);
        check("rst_mismatch", {31'd0, Mismatch}, 0);
        step();
        Rst_n = 1'b1;
        step();

        // 1: 1011, MSB-first D sequence and latency
        w = 4'b1011;
        Out_ready = 1'b1;
        Load_data = w; Load_valid = 1'b1;
        exp_q.push_back('{data: 4'hB, mism: 1'b0});
        step();
        Load_valid = 1'b0; Load_data = 4'h0;
        for (int i = 0; i < W; i++) begin
            check("t1_shift_en", {31'd0, Shift_en}, 1);
            check("t1_d", {31'd0, D}, {31'd0, w[W-1-i]});
            check("t1_busy", {31'd0, Busy}, 1);
            step();
        end
        check("t1_shift_en_off", {31'd0, Shift_en}, 0);
        check("t1_early_valid", {31'd0, Out_valid}, 0);
        step();
        check("t1_valid_at_5", {31'd0, Out_valid}, 1);
        step();
        check("t1_valid_drop", {31'd0, Out_valid}, 0);
        check("t1_load_ready", {31'd0, Load_ready}, 1);

        // 2: hold under backpressure
        Out_ready = 1'b0;
        Load_data = 4'h6; Load_valid = 1'b1;
        exp_q.push_back('{data: 4'h6, mism: 1'b0});
        step();
        Load_valid = 1'b0;
        step(5);
        for (int i = 0; i < 10; i++) begin
            check("t2_hold_valid", {31'd0, Out_valid}, 1);
            check("t2_hold_data", {28'd0, Out_data}, 32'h6);
            check("t2_load_ready", {31'd0, Load_ready}, 0);
            step();
        end
        Out_ready = 1'b1;
        step();
        check("t2_valid_drop", {31'd0, Out_valid}, 0);
        check("t2_load_ready_up", {31'd0, Load_ready}, 1);

        // 3: back-to-back loads with Load_valid held
        Load_data = 4'hF; Load_valid = 1'b1;
        exp_q.push_back('{data: 4'hF, mism: 1'b0});
        exp_q.push_back('{data: 4'h0, mism: 1'b0});
        step();
        Load_data = 4'h0;
        step(5);
        check("t3_first_valid", {31'd0, Out_valid}, 1);
        step();
        check("t3_handshake", {31'd0, Out_valid}, 0);
        check("t3_idle_gap", {31'd0, Load_ready}, 1);
        step();
        check("t3_second_accept", {31'd0, Shift_en}, 1);
        check("t3_second_busy", {31'd0, Busy}, 1);
        check("t3_second_d", {31'd0, D}, 0);
        Load_valid = 1'b0;
        step(5);
        check("t3_second_valid", {31'd0, Out_valid}, 1);
        step();

        // 4: flush in the 2nd shift cycle of 4'hA
        Load_data = 4'hA; Load_valid = 1'b1;
        step();
        Load_valid = 1'b0;
        step();
        check("t4_2nd_shift", {31'd0, Shift_en}, 1);
        Flush = 1'b1;
        step();
        Flush = 1'b0;
        check("t4_flush_shift_en", {31'd0, Shift_en}, 0);
        check("t4_flush_busy", {31'd0, Busy}, 0);
        check("t4_flush_d", {31'd0, D}, 0);
        check("t4_flush_ready", {31'd0, Load_ready}, 1);
        step(6);
        check("t4_no_valid", {31'd0, Out_valid}, 0);
        Load_data = 4'h3; Load_valid = 1'b1;
        exp_q.push_back('{data: 4'h3, mism: 1'b0});
        step();
        Load_valid = 1'b0;
        step(6);

        // 7: flush in HOLD keeps Out_data
        Out_ready = 1'b0;
        Load_data = 4'h5; Load_valid = 1'b1;
        exp_q.push_back('{data: 4'h5, mism: 1'b0});
        step();
        Load_valid = 1'b0;
        step(6);
        Flush = 1'b1;
        step();
        Flush = 1'b0;
        check("t7_flush_valid", {31'd0, Out_valid}, 0);
        check("t7_flush_data_kept", {28'd0, Out_data}, 32'h5);
        check("t7_flush_busy", {31'd0, Busy}, 0);
        Out_ready = 1'b1;

        // 5: async reset mid-SHIFT
        Load_data = 4'h9; Load_valid = 1'b1;
        step();
        Load_valid = 1'b0;
        step();
        #2 Rst_n = 1'b0;
        #1;
        check("t5_shift_en", {31'd0, Shift_en}, 0);
        check("t5_out_valid", {31'd0, Out_valid}, 0);
        check("t5_busy", {31'd0, Busy}, 0);
        check("t5_load_ready", {31'd0, Load_ready}, 1);
        check("t5_out_data", {28'd0, Out_data}, 0);
        step();
        Rst_n = 1'b1;
        step();

        // 6: Q[2] stuck-at-0
        stuck = 1'b1;
        Load_data = 4'hF; Load_valid = 1'b1;
        exp_q.push_back('{data: 4'hB, mism: STUCK_MISM});
        step();
        Load_valid = 1'b0;
        step(6);
        check("t6_mism_cleared", {31'd0, Mismatch}, 0);
        stuck = 1'b0;
        step(3);

        check("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
